// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - copy/fill block engine driving the 8-entry data memory port
module mem_block_mover #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op,
    input  logic [2:0]      src_addr,
    input  logic [2:0]      dst_addr,
    input  logic [3:0]      count,
    input  logic [size-1:0] fill_data,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            MW,
    output logic [2:0]      AddressOfMemory,
    output logic [size-1:0] dataInMemory,
    input  logic [size-1:0] dataOutFromMemory
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic            op_q;
    logic [2:0]      src_ptr;
    logic [2:0]      dst_ptr;
    logic [3:0]      remaining;
    logic [size-1:0] fill_q;
    logic [size-1:0] data_q;
    logic            err_q;

    // Sequencer: accepts a request in IDLE, then alternates RD/WR (copy) or repeats WR (fill).
    // Pointers are 3 bits wide so the increment wraps 7 -> 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= 1'b0;
            src_ptr   <= 3'd0;
            dst_ptr   <= 3'd0;
            remaining <= 4'd0;
            fill_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count > 4'd8) begin
                            err_q <= 1'b1;
                        end else if (count == 4'd0) begin
                            state <= DONE;
                        end else begin
                            op_q      <= op;
                            src_ptr   <= src_addr;
                            dst_ptr   <= dst_addr;
                            remaining <= count;
                            fill_q    <= fill_data;
                            state     <= op ? WR : RD;
                        end
                    end
                end
                RD: begin
                    data_q <= dataOutFromMemory;
                    state  <= WR;
                end
                WR: begin
                    src_ptr   <= src_ptr + 3'd1;
                    dst_ptr   <= dst_ptr + 3'd1;
                    remaining <= remaining - 4'd1;
                    if (remaining == 4'd1) begin
                        state <= DONE;
                    end else begin
                        state <= op_q ? WR : RD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port and status decoded from registered state only, so reset clears them at once.
    always_comb begin
        busy            = (state == RD) || (state == WR);
        done            = (state == DONE);
        err             = err_q;
        MW              = (state == WR);
        AddressOfMemory = 3'd0;
        dataInMemory    = '0;
        if (state == RD) begin
            AddressOfMemory = src_ptr;
        end else if (state == WR) begin
            AddressOfMemory = dst_ptr;
            dataInMemory    = op_q ? fill_q : data_q;
        end
    end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Initiator-side engine for the 8-entry single-port data memory. It drives the memory write enable, address and write data, and samples the memory's combinational read data.
- On a start pulse it performs one of two block operations, then signals completion:
  - copy: N words from src to dst
  - fill: writes a constant to N words
- It sits between the control unit and the data memory, and owns the memory port while busy.

Parameters:
- size, 8, data word width in bits (matches data memory word width)

Ports:
- clk  input  1  rising-edge clock, shared with the data memory
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  1  0 = copy, 1 = fill
- src_addr  input  3  first source address (copy only)
- dst_addr  input  3  first destination address
- count  input  4  number of words, legal range 0..8
- fill_data  input  size  constant written in fill mode
- busy  output  1  high in RD and WR states
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse on rejected request
- MW  output  1  memory write enable
- AddressOfMemory  output  3  memory address
- dataInMemory  output  size  memory write data
- dataOutFromMemory  input  size  memory read data; combinational from AddressOfMemory

Behaviour:
- States: IDLE, RD, WR, DONE. The state register is reset asynchronously to IDLE.
- Reset values: busy=0, done=0, err=0, MW=0, AddressOfMemory=0, dataInMemory=0.
  - MW is decoded from the state register only (Moore), so asserting rst_n low drops MW immediately.
  - Reset mid-operation abandons the block. Words already written stay written; no done pulse is issued.
- IDLE: MW=0, AddressOfMemory=0, dataInMemory=0. At a clk edge with start=1:
  - count > 8: stay IDLE, err=1 for the next cycle, no memory access.
  - count == 0: go to DONE with no memory access.
  - otherwise: latch op, src_ptr=src_addr, dst_ptr=dst_addr, remaining=count, fill_q=fill_data. Go to RD if op=0, WR if op=1.
- RD (copy only): MW=0, AddressOfMemory=src_ptr. At the edge, capture dataOutFromMemory into data_q and go to WR.
- WR: MW=1, AddressOfMemory=dst_ptr, dataInMemory = data_q (copy) or fill_q (fill). The memory writes on this edge. At the edge:
  - src_ptr and dst_ptr increment modulo 8 (7 wraps to 0).
  - remaining decrements.
  - If remaining was 1, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE. A start arriving in DONE is ignored.
- start while busy or in DONE is ignored; latched parameters cannot change mid-block.
- Latency from the start edge to the done cycle:
  - copy: 2N+1 cycles
  - fill: N+1 cycles
  - count=0: 1 cycle
- Transfer order is always ascending address with wrap. Overlapping copy with dst inside (src, src+N) reads already-overwritten words; this is defined behaviour, not an error.
- src == dst copy is legal; memory contents are unchanged.
- count == 8 touches every location exactly once.
- Outside WR, dataInMemory is 0 and MW is 0. Outside RD/WR, AddressOfMemory is 0.

Test Plan:
- Fill, normal: op=1, dst=2, count=3, fill_data=0xA5 -> MW high for exactly 3 cycles at addresses 2,3,4; mem[2..4]=0xA5, others unchanged; done pulses 4 cycles after the start edge.
- Copy, normal: preload mem[i]=0x10+i; op=0, src=0, dst=4, count=4 -> alternating RD/WR; mem[4..7]=0x10..0x13; done exactly 9 cycles after start; busy high for 8 cycles.
- Wrap-around: preload mem[i]=i; copy src=6, dst=1, count=3 -> mem[1]=6, mem[2]=7, mem[3]=0; pointers wrap 7->0.
- Boundaries:
  - count=0 -> done next cycle, MW never asserted.
  - count=9 -> err pulse of one cycle, no done, MW never high.
  - count=8 fill 0xFF -> all 8 words 0xFF.
- start while busy: second start with different params issued mid-copy -> ignored; the first block completes unchanged with a single done pulse.
- Async reset mid-block: assert rst_n=0 between edges during WR of a count=5 fill -> MW, busy, done drop to 0 immediately; only words written before reset changed; after release a new request runs normally.
